// File: rtl/lim_inc_pkg.sv
// Shared constants and limited-sum helpers for the lim_inc digit incrementor.
// The helpers work on a 33-bit zero-extended sum so any WIDTH up to 32 fits.
package lim_inc_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32'd4;
    localparam int unsigned DEFAULT_LIMIT = 32'd7;

    // Carry-out: the full sum has gone past the inclusive limit.
    function automatic logic lim_co(input logic [32:0] s, input logic [31:0] lim);
        return (s > {1'b0, lim});
    endfunction

    // Limited sum: wraps to zero once the limit is exceeded.
    function automatic logic [32:0] lim_sum(input logic [32:0] s, input logic [31:0] lim);
        logic [32:0] r;
        if (s > {1'b0, lim}) begin
            r = 33'd0;
        end else begin
            r = s;
        end
        return r;
    endfunction

endpackage

// File: rtl/lim_inc_core.sv
// Combinational limited incrementor: sum_c = (a + ci > L) ? 0 : a + ci, co_c flags the wrap.
// Chaining co_c into the next core's ci builds multi-digit counters with no added latency.
module lim_inc_core
    import lim_inc_pkg::*;
#(
    parameter int unsigned L     = DEFAULT_LIMIT,
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic             ci,
    output logic [WIDTH-1:0] sum_c,
    output logic             co_c
);

    logic [WIDTH:0] s_s;

    // One extra bit keeps a = max with ci = 1 from wrapping silently.
    always_comb begin
        s_s   = {1'b0, a} + {{WIDTH{1'b0}}, ci};
        co_c  = lim_co(33'(s_s), 32'(L));
        sum_c = WIDTH'(lim_sum(33'(s_s), 32'(L)));
    end

endmodule

// File: rtl/lim_inc.sv
// Registered limited incrementor: one clock of latency with a valid flag.
// Results hold while in_valid is low; out_valid follows in_valid by one edge.
module lim_inc
    import lim_inc_pkg::*;
#(
    parameter int unsigned L     = DEFAULT_LIMIT,
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic             ci,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             out_valid
);

    logic [WIDTH-1:0] sum_c_s;
    logic             co_c_s;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             co_d, co_q;
    logic             valid_d, valid_q;

    lim_inc_core #(
        .L     (L),
        .WIDTH (WIDTH)
    ) u_core (
        .a     (a),
        .ci    (ci),
        .sum_c (sum_c_s),
        .co_c  (co_c_s)
    );

    // Next-state: capture the core result only on a valid sample.
    always_comb begin
        sum_d   = sum_q;
        co_d    = co_q;
        valid_d = in_valid;
        if (in_valid) begin
            sum_d = sum_c_s;
            co_d  = co_c_s;
        end else begin
            sum_d = sum_q;
            co_d  = co_q;
        end
    end

    // Output register stage with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= {WIDTH{1'b0}};
            co_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            co_q    <= co_d;
            valid_q <= valid_d;
        end
    end

    assign sum       = sum_q;
    assign co        = co_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_lim_inc.sv
// Self-checking bench for lim_inc: four instances (L = 7, 15, 9, 0) share stimulus.
// Expected values come from directed constants and a plain-arithmetic reference model.
module tb_lim_inc;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic       ci;
    logic [3:0] sum_o [4];
    logic       co_o  [4];
    logic       ov_o  [4];

    int checks;
    int failures;
    int lims [4];

    lim_inc #(.L(7),  .WIDTH(4)) u_l7  (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .ci(ci),
                                        .sum(sum_o[0]), .co(co_o[0]), .out_valid(ov_o[0]));
    lim_inc #(.L(15), .WIDTH(4)) u_l15 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .ci(ci),
                                        .sum(sum_o[1]), .co(co_o[1]), .out_valid(ov_o[1]));
    lim_inc #(.L(9),  .WIDTH(4)) u_l9  (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .ci(ci),
                                        .sum(sum_o[2]), .co(co_o[2]), .out_valid(ov_o[2]));
    lim_inc #(.L(0),  .WIDTH(4)) u_l0  (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .ci(ci),
                                        .sum(sum_o[3]), .co(co_o[3]), .out_valid(ov_o[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer sum, wrap to zero past the limit.
    function automatic int ref_sum(input int av, input int cv, input int lim);
        int s;
        s = av + cv;
        return (s > lim) ? 0 : s;
    endfunction

    function automatic int ref_co(input int av, input int cv, input int lim);
        return ((av + cv) > lim) ? 1 : 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; a = 4'd0; ci = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (sum_o[k] !== 4'd0 || co_o[k] !== 1'b0 || ov_o[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset_init[%0d]: got sum=%0d co=%0b ov=%0b, want 0 0 0", k, sum_o[k], co_o[k], ov_o[k]);
            end
        end
        #2 rst_n = 1'b1;
        in_valid = 1'b1; a = 4'd4; ci = 1'b1;
        step();
        checks++;
        if (sum_o[0] !== 4'd5 || co_o[0] !== 1'b0 || ov_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre: got sum=%0d co=%0b ov=%0b, want 5 0 1", sum_o[0], co_o[0], ov_o[0]);
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (sum_o[0] !== 4'd0 || co_o[0] !== 1'b0 || ov_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: got sum=%0d co=%0b ov=%0b, want 0 0 0", sum_o[0], co_o[0], ov_o[0]);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (sum_o[0] !== 4'd0 || co_o[0] !== 1'b0 || ov_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_after: got sum=%0d co=%0b ov=%0b, want 0 0 0", sum_o[0], co_o[0], ov_o[0]);
        end
    endtask

    task automatic test_exhaustive();
        int es, ec;
        for (int av = 0; av < 16; av++) begin
            for (int cv = 0; cv < 2; cv++) begin
                in_valid = 1'b1; a = 4'(av); ci = 1'(cv);
                step();
                if (av + cv <= 7) begin es = av + cv; ec = 0; end
                else begin es = 0; ec = 1; end
                checks++;
                if (sum_o[0] !== 4'(es) || co_o[0] !== 1'(ec) || ov_o[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL exh_l7 a=%0d ci=%0d: got sum=%0d co=%0b ov=%0b, want %0d %0d 1",
                             av, cv, sum_o[0], co_o[0], ov_o[0], es, ec);
                end
            end
        end
    endtask

    task automatic test_hold();
        in_valid = 1'b1; a = 4'd3; ci = 1'b1;
        step();
        checks++;
        if (sum_o[0] !== 4'd4 || co_o[0] !== 1'b0 || ov_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL hold_load: got sum=%0d co=%0b ov=%0b, want 4 0 1", sum_o[0], co_o[0], ov_o[0]);
        end
        in_valid = 1'b0; a = 4'd7;
        step();
        checks++;
        if (sum_o[0] !== 4'd4 || co_o[0] !== 1'b0 || ov_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL hold_keep: got sum=%0d co=%0b ov=%0b, want 4 0 0", sum_o[0], co_o[0], ov_o[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq_a [3];
        logic [3:0] exp_s [3];
        logic       exp_c [3];
        seq_a = '{4'd7, 4'd0, 4'd7};
        exp_s = '{4'd0, 4'd1, 4'd0};
        exp_c = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = seq_a[i]; ci = 1'b1;
            step();
            checks++;
            if (sum_o[0] !== exp_s[i] || co_o[0] !== exp_c[i] || ov_o[0] !== 1'b1) begin
                failures++;
                $display("FAIL b2b[%0d]: got sum=%0d co=%0b ov=%0b, want %0d %0b 1",
                         i, sum_o[0], co_o[0], ov_o[0], exp_s[i], exp_c[i]);
            end
        end
    endtask

    task automatic test_boundaries();
        // columns: instance, a, ci, expected sum, expected co
        int tbl [9][5];
        tbl = '{'{1, 14, 1, 15, 0}, '{1, 15, 1, 0, 1}, '{1, 15, 0, 15, 0},
                '{2, 9, 0, 9, 0},   '{2, 9, 1, 0, 1},  '{2, 12, 0, 0, 1},
                '{3, 0, 0, 0, 0},   '{3, 0, 1, 0, 1},  '{0, 9, 0, 0, 1}};
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; a = 4'(tbl[i][1]); ci = 1'(tbl[i][2]);
            step();
            checks++;
            if (sum_o[tbl[i][0]] !== 4'(tbl[i][3]) || co_o[tbl[i][0]] !== 1'(tbl[i][4])) begin
                failures++;
                $display("FAIL bound L=%0d a=%0d ci=%0d: got sum=%0d co=%0b, want %0d %0d",
                         lims[tbl[i][0]], tbl[i][1], tbl[i][2], sum_o[tbl[i][0]], co_o[tbl[i][0]],
                         tbl[i][3], tbl[i][4]);
            end
        end
    endtask

    task automatic test_random();
        int es [4];
        int ec [4];
        int ev, av, cv, vv;
        for (int n = 0; n < 300; n++) begin
            av = int'($urandom_range(15, 0));
            cv = int'($urandom_range(1, 0));
            vv = (n == 0) ? 1 : int'($urandom_range(3, 0) != 0);
            in_valid = 1'(vv); a = 4'(av); ci = 1'(cv);
            step();
            ev = vv;
            for (int k = 0; k < 4; k++) begin
                if (vv != 0) begin
                    es[k] = ref_sum(av, cv, lims[k]);
                    ec[k] = ref_co(av, cv, lims[k]);
                end
                checks++;
                if (sum_o[k] !== 4'(es[k]) || co_o[k] !== 1'(ec[k]) || ov_o[k] !== 1'(ev)) begin
                    failures++;
                    $display("FAIL rand[%0d] L=%0d a=%0d ci=%0d v=%0d: got sum=%0d co=%0b ov=%0b, want %0d %0d %0d",
                             n, lims[k], av, cv, vv, sum_o[k], co_o[k], ov_o[k], es[k], ec[k], ev);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        lims = '{7, 15, 9, 0};
        test_reset();
        test_exhaustive();
        test_hold();
        test_back_to_back();
        test_boundaries();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
